// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, reset vector and fetch state encoding
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam int WORD_BYTES = 4;
  localparam int WORD_LSB = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction-memory fetch bus between PC sequencer and imem/adder
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = mips_pkg::ADDR_W
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              imem_req;
  logic              imem_ready;
  logic              instr_valid;

  modport master (
    output pc,
    output imem_req,
    output instr_valid,
    input  pc_plus4,
    input  imem_ready
  );

  modport slave (
    input  pc,
    input  imem_req,
    input  instr_valid,
    output pc_plus4,
    output imem_ready
  );

endinterface

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC priority select and word-alignment check
module pc_next_mux #(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_pc_plus4,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump_en,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_pend_valid,
  input  logic [ADDR_W-1:0] i_pend_target,
  output logic              o_redir_valid,
  output logic [ADDR_W-1:0] o_redir_target,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_misaligned
);
  import mips_pkg::*;

  logic              w_redir_valid;
  logic [ADDR_W-1:0] w_redir_target;
  logic [ADDR_W-1:0] w_next_pc;

  // Live redirect (jump beats branch) beats a remembered one, which beats sequential flow
  always_comb begin
    w_redir_valid  = i_jump_en | i_branch_taken;
    w_redir_target = i_jump_en ? i_jump_target : i_branch_target;
    if (w_redir_valid) begin
      w_next_pc = w_redir_target;
    end else if (i_pend_valid) begin
      w_next_pc = i_pend_target;
    end else begin
      w_next_pc = i_pc_plus4;
    end
  end

  assign o_redir_valid  = w_redir_valid;
  assign o_redir_target = w_redir_target;
  assign o_next_pc      = w_next_pc;
  assign o_misaligned   = |w_next_pc[WORD_LSB-1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register and fetch handshake sequencer with redirect capture and misalign trap
module pc_fetch_ctrl #(
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_fetch_ctrl_if.master   bus,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump_en,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_stall,
  output logic              o_misalign_err
);
  import mips_pkg::*;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_target;
  logic              r_pend_valid;
  logic              r_imem_req;
  logic              r_instr_valid;
  logic              r_misalign_err;

  logic              w_accept;
  logic              w_redir_valid;
  logic [ADDR_W-1:0] w_redir_target;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_next_misaligned;

  pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
    .i_pc_plus4      (bus.pc_plus4),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump_en       (i_jump_en),
    .i_jump_target   (i_jump_target),
    .i_pend_valid    (r_pend_valid),
    .i_pend_target   (r_pend_target),
    .o_redir_valid   (w_redir_valid),
    .o_redir_target  (w_redir_target),
    .o_next_pc       (w_next_pc),
    .o_misaligned    (w_next_misaligned)
  );

  // An instruction is consumed only while actively fetching with imem and downstream both ready
  assign w_accept = (r_state == FETCH) & bus.imem_ready & ~i_stall;

  // Fetch FSM; imem_req and instr_valid are registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= BOOT;
      r_pc           <= RESET_PC;
      r_pend_target  <= '0;
      r_pend_valid   <= 1'b0;
      r_imem_req     <= 1'b0;
      r_instr_valid  <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (w_accept) begin
            if (w_next_misaligned) begin
              r_state        <= HALT;
              r_imem_req     <= 1'b0;
              r_misalign_err <= 1'b1;
            end else begin
              r_pc          <= w_next_pc;
              r_instr_valid <= 1'b1;
              r_pend_valid  <= 1'b0;
            end
          end else if (bus.imem_ready) begin
            // imem answered but downstream is full: drop the response and re-ask later
            r_state    <= STALL;
            r_imem_req <= 1'b0;
          end
        end
        STALL: begin
          if (!i_stall) begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= HALT;
        end
      endcase
      // Redirects that miss an accept are remembered; the newest one wins
      if ((r_state != HALT) && !w_accept && w_redir_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_redir_target;
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.imem_req    = r_imem_req;
  assign bus.instr_valid = r_instr_valid;
  assign o_misalign_err  = r_misalign_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed and randomized checks of the PC fetch sequencer
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        misalign_err;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_req, m_valid, m_err;
  logic        m_booting, m_stalled, m_halted;
  logic        m_pend;
  logic [31:0] m_pend_t;

  pc_fetch_ctrl_if bus ();

  // the PC+4 adder
  assign bus.pc_plus4 = bus.pc + 32'd4;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump_en       (jump_en),
    .i_jump_target   (jump_target),
    .i_stall         (stall),
    .o_misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic jmp, input logic [31:0] jt, input logic br,
                       input logic [31:0] bt, input logic st, input logic rdy);
    jump_en = jmp; jump_target = jt; branch_taken = br; branch_target = bt;
    stall = st; bus.imem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_req = 0; m_valid = 0; m_err = 0;
    m_booting = 1; m_stalled = 0; m_halted = 0; m_pend = 0; m_pend_t = '0;
  endtask

  task automatic model_clock(input logic jmp, input logic [31:0] jt, input logic br,
                             input logic [31:0] bt, input logic st, input logic rdy);
    logic [31:0] np;
    if (m_halted) return;
    m_valid = 0;
    if (!m_booting && !m_stalled && rdy && !st) begin
      np = jmp ? jt : br ? bt : m_pend ? m_pend_t : m_pc + 32'd4;
      if (np % 4 != 0) begin
        m_halted = 1; m_err = 1; m_req = 0;
      end else begin
        m_pc = np; m_valid = 1; m_pend = 0;
      end
      return;
    end
    if (m_booting) begin
      m_booting = 0; m_req = 1;
    end else if (m_stalled) begin
      if (!st) begin m_stalled = 0; m_req = 1; end
    end else if (rdy) begin
      m_stalled = 1; m_req = 0;
    end
    if (jmp || br) begin
      m_pend = 1;
      m_pend_t = jmp ? jt : bt;
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    t[1:0] = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return t;
  endfunction

  task automatic test_reset();
    bus.imem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++; if (bus.pc !== RESET_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, RESET_PC); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_boot_seq();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL boot_idle_req got=%b exp=0", bus.imem_req); end
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 0, '0, 0, 1);
      total++; if (bus.pc !== exp_pc[i]) begin bad++; $display("FAIL boot_pc[%0d] got=%h exp=%h", i, bus.pc, exp_pc[i]); end
      total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL boot_req[%0d] got=%b exp=1", i, bus.imem_req); end
      total++; if (bus.instr_valid !== (i > 0)) begin bad++; $display("FAIL boot_valid[%0d] got=%b exp=%b", i, bus.instr_valid, i > 0); end
    end
  endtask

  task automatic test_jump_priority();
    drive(1, 32'h100, 1, 32'h80, 0, 1);
    total++; if (bus.pc !== 32'h100) begin bad++; $display("FAIL jump_prio_pc got=%h exp=00000100", bus.pc); end
    drive(0, '0, 0, '0, 0, 1);
    total++; if (bus.pc !== 32'h104) begin bad++; $display("FAIL jump_prio_next got=%h exp=00000104", bus.pc); end
  endtask

  task automatic test_pending();
    drive(1, 32'h20, 0, '0, 0, 1);
    drive(0, '0, 1, 32'h40, 0, 0);
    total++; if (bus.pc !== 32'h20) begin bad++; $display("FAIL pend_hold1 got=%h exp=00000020", bus.pc); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL pend_valid0 got=%b exp=0", bus.instr_valid); end
    drive(0, '0, 0, '0, 0, 0);
    total++; if (bus.pc !== 32'h20) begin bad++; $display("FAIL pend_hold2 got=%h exp=00000020", bus.pc); end
    drive(0, '0, 0, '0, 0, 1);
    total++; if (bus.pc !== 32'h40) begin bad++; $display("FAIL pend_take got=%h exp=00000040", bus.pc); end
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL pend_valid1 got=%b exp=1", bus.instr_valid); end
    drive(0, '0, 0, '0, 0, 1);
    total++; if (bus.pc !== 32'h44) begin bad++; $display("FAIL pend_cleared got=%h exp=00000044", bus.pc); end
  endtask

  task automatic test_stall();
    drive(1, 32'h30, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, '0, 1, 1);
      total++; if (bus.pc !== 32'h30) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=00000030", i, bus.pc); end
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", i, bus.imem_req); end
      total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=0", i, bus.instr_valid); end
    end
    drive(0, '0, 0, '0, 0, 1);
    total++; if (bus.pc !== 32'h30) begin bad++; $display("FAIL stall_refetch_pc got=%h exp=00000030", bus.pc); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL stall_refetch_req got=%b exp=1", bus.imem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL stall_refetch_valid got=%b exp=0", bus.instr_valid); end
    drive(0, '0, 0, '0, 0, 1);
    total++; if (bus.pc !== 32'h34) begin bad++; $display("FAIL stall_resume got=%h exp=00000034", bus.pc); end
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_resume_valid got=%b exp=1", bus.instr_valid); end
  endtask

  task automatic test_wrap();
    drive(1, 32'hFFFF_FFFC, 0, '0, 0, 1);
    total++; if (bus.pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", bus.pc); end
    drive(0, '0, 0, '0, 0, 1);
    total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=00000000", bus.pc); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", misalign_err); end
  endtask

  task automatic test_misalign();
    drive(1, 32'h200, 0, '0, 0, 1);
    drive(1, 32'h102, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.pc !== 32'h200) begin bad++; $display("FAIL halt_pc[%0d] got=%h exp=00000200", i, bus.pc); end
      total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL halt_err[%0d] got=%b exp=1", i, misalign_err); end
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL halt_req[%0d] got=%b exp=0", i, bus.imem_req); end
      total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL halt_valid[%0d] got=%b exp=0", i, bus.instr_valid); end
      drive(1'($urandom), {$urandom, 2'b00}, 1'($urandom), {$urandom, 2'b00}, 0, 1);
    end
    rst_n = 1'b0;
    #2;
    total++; if (bus.pc !== RESET_PC) begin bad++; $display("FAIL halt_reset_pc got=%h exp=%h", bus.pc, RESET_PC); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL halt_reset_err got=%b exp=0", misalign_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic jmp, br, st, rdy;
    logic [31:0] jt, bt;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 800; i++) begin
      if (m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0)) begin
        rst_n = 1'b0; #2;
        total++;
        if (bus.pc !== RESET_PC || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
          bad++; $display("FAIL rnd_reset[%0d] got=%h/%b/%b/%b exp=%h/0/0/0", i, bus.pc, bus.imem_req, bus.instr_valid, misalign_err, RESET_PC);
        end
        rst_n = 1'b1;
        model_reset();
      end
      jmp = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 5) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      jt  = rand_target();
      bt  = rand_target();
      drive(jmp, jt, br, bt, st, rdy);
      model_clock(jmp, jt, br, bt, st, rdy);
      total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, bus.pc, m_pc); end
      total++; if (bus.imem_req !== m_req) begin bad++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, bus.imem_req, m_req); end
      total++; if (bus.instr_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.instr_valid, m_valid); end
      total++; if (misalign_err !== m_err) begin bad++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, misalign_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_jump_priority();
    test_pending();
    test_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
